// File: rtl/memory_arbiter.sv
// Serializes instruction fetches and data loads/stores onto one single-ported RAM.
// Data requests win; one access in flight; each completes with a one-cycle hit pulse.
module memory_arbiter #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dhit,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, DACC, IACC, DRESP, IRESP} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // The RAM-side outputs double as the latched request, so live inputs are
  // never consulted again once an access has started.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      err      <= 1'b0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE: begin
          if (dREN || dWEN) begin
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= !dWEN;
            cnt      <= '0;
            state    <= DACC;
          end else if (iREN) begin
            ramaddr <= iaddr;
            ramWEN  <= 1'b0;
            ramREN  <= 1'b1;
            cnt     <= '0;
            state   <= IACC;
          end
        end
        DACC, IACC: begin
          if (ramready || cnt == LAST) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (!ramready) err <= 1'b1;
            if (state == DACC) begin
              dload <= ramready ? ramload : '0;
              dhit  <= 1'b1;
              state <= DRESP;
            end else begin
              iload <= ramready ? ramload : '0;
              ihit  <= 1'b1;
              state <= IRESP;
            end
          end else begin
            // Abort fires at LAST, so the count tops out there and never wraps.
            cnt <= cnt + 1'b1;
          end
        end
        DRESP, IRESP: state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

endmodule
